// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//
// Moore control sequencer for the 32-bit shared datapath bus. It runs one
// instruction fetch followed by one 3-register ALU instruction:
//   fetch   : PC->MAR (Z<=PC+1), Zlow->PC while memory reads into MDR, MDR->IR
//   execute : Rb->Y, Rc op Y->Z, then Z->Ra, or Zlow->LO and Zhigh->HI
//             for multiply/divide.
// Exactly one bus source is enabled in any non-idle cycle, and never more
// than one register-file load strobe.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               request one fetch+execute (accepted only in IDLE)
//   mem_ready           memory read data valid (only looked at in T1)
//   ir_op/ra/rb/rc      decoded instruction fields from IR
//   bus_src[23:0]       one-hot bus source select
//                       [15:0] R0..R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow,
//                       20 PC, 21 MDR, 22 InPort, 23 C
//   reg_in[15:0]        one-hot register-file load strobe
//   pc_in .. lo_in      single register load strobes
//   inc_pc              ALU computes bus+1
//   mem_read            memory read request
//   alu_op              ALU opcode, ir_op during T4 only
//   busy                sequencer is not idle
//   done                one-cycle pulse in the final writeback state
//   error               sticky memory-timeout flag
// -----------------------------------------------------------------------------
module bus_sequencer #(
    parameter int         MEM_WAIT_MAX = 15,
    parameter logic [4:0] MUL_OP       = 5'b01111,
    parameter logic [4:0] DIV_OP       = 5'b10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [4:0]  ir_op,
    input  logic [3:0]  ir_ra,
    input  logic [3:0]  ir_rb,
    input  logic [3:0]  ir_rc,
    output logic [23:0] bus_src,
    output logic [15:0] reg_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        inc_pc,
    output logic        mem_read,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    // Bus-source bit positions for the non-register sources.
    localparam int SRC_ZHIGH = 18;
    localparam int SRC_ZLOW  = 19;
    localparam int SRC_PC    = 20;
    localparam int SRC_MDR   = 21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          error_reg, error_next;

    // One-hot decodes of the register index fields.
    logic [15:0] ra_onehot;
    logic [15:0] rb_onehot;
    logic [15:0] rc_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg_decode
            assign ra_onehot[gi] = (ir_ra == 4'(gi));
            assign rb_onehot[gi] = (ir_rb == 4'(gi));
            assign rc_onehot[gi] = (ir_rc == 4'(gi));
        end
    endgenerate

    logic is_muldiv;
    assign is_muldiv = (ir_op == MUL_OP) || (ir_op == DIV_OP);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            error_reg    <= error_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        error_next    = error_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_T0;
                    error_next = 1'b0;
                end
            end
            S_T0: begin
                state_next    = S_T1;
                wait_cnt_next = '0;
            end
            S_T1: begin
                // The counter holds the number of T1 cycles already spent
                // without ready, so the abort happens on the last allowed one.
                if (mem_ready) begin
                    state_next = S_T2;
                end else if (wait_cnt_reg == CW'(MEM_WAIT_MAX - 1)) begin
                    state_next = S_IDLE;
                    error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CW'(1);
                end
            end
            S_T2: state_next = S_T3;
            S_T3: state_next = S_T4;
            S_T4: state_next = S_T5;
            S_T5: state_next = is_muldiv ? S_T6 : S_IDLE;
            S_T6: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: from state, plus the IR fields that select
    // which register drives or loads)
    // ------------------------------------------------------------------
    always_comb begin
        bus_src  = '0;
        reg_in   = '0;
        pc_in    = 1'b0;
        ir_in    = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        inc_pc   = 1'b0;
        mem_read = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        case (state_reg)
            S_T0: begin
                bus_src[SRC_PC] = 1'b1;
                mar_in          = 1'b1;
                inc_pc          = 1'b1;
                z_in            = 1'b1;
            end
            S_T1: begin
                // Reloading PC from Zlow every wait cycle is harmless:
                // Z does not change while waiting.
                bus_src[SRC_ZLOW] = 1'b1;
                pc_in             = 1'b1;
                mem_read          = 1'b1;
                mdr_in            = 1'b1;
            end
            S_T2: begin
                bus_src[SRC_MDR] = 1'b1;
                ir_in            = 1'b1;
            end
            S_T3: begin
                bus_src[15:0] = rb_onehot;
                y_in          = 1'b1;
            end
            S_T4: begin
                bus_src[15:0] = rc_onehot;
                z_in          = 1'b1;
                alu_op        = ir_op;
            end
            S_T5: begin
                bus_src[SRC_ZLOW] = 1'b1;
                if (is_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    reg_in = ra_onehot;
                    done   = 1'b1;
                end
            end
            S_T6: begin
                bus_src[SRC_ZHIGH] = 1'b1;
                hi_in              = 1'b1;
                done               = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state_reg != S_IDLE);
    assign error = error_reg;

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
//
// Self-checking bench for bus_sequencer. The reference model turns an
// instruction (opcode, register fields, memory wait length) into the list of
// per-cycle control words the sequencer should produce, straight from the
// state/output table of the sequencer's description. A table of directed
// instructions with independently stated latencies is run first, then
// hand-written reset / start-handling sequences, then random instructions.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

    localparam logic [4:0] MUL_OP = 5'b01111;
    localparam logic [4:0] DIV_OP = 5'b10000;
    localparam int NO_READY = 15;   // wait value meaning mem_ready never comes

    // Strobe vector bit positions: {pc,ir,mar,mdr,y,z,hi,lo}
    localparam int B_PC = 7, B_IR = 6, B_MAR = 5, B_MDR = 4;
    localparam int B_Y = 3, B_Z = 2, B_HI = 1, B_LO = 0;

    logic        clock = 1'b0;
    logic        reset, start, mem_ready;
    logic [4:0]  ir_op;
    logic [3:0]  ir_ra, ir_rb, ir_rc;
    logic [23:0] bus_src;
    logic [15:0] reg_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic        inc_pc, mem_read, busy, done, error;
    logic [4:0]  alu_op;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bus_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mem_ready (mem_ready),
        .ir_op     (ir_op),
        .ir_ra     (ir_ra),
        .ir_rb     (ir_rb),
        .ir_rc     (ir_rc),
        .bus_src   (bus_src),
        .reg_in    (reg_in),
        .pc_in     (pc_in),
        .ir_in     (ir_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .inc_pc    (inc_pc),
        .mem_read  (mem_read),
        .alu_op    (alu_op),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Observed control word: bus(24) reg(16) strobes(8) inc mrd alu(5) busy done err
    logic [57:0] obs;
    assign obs = {bus_src, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                  hi_in, lo_in, inc_pc, mem_read, alu_op, busy, done, error};

    typedef struct {
        logic [23:0] bus;
        logic [15:0] rin;
        logic [7:0]  strb;
        logic        inc;
        logic        mrd;
        logic [4:0]  alu;
        logic        bsy;
        logic        dn;
        logic        err;
        logic        mr;     // mem_ready value the bench drives in this cycle
    } cyc_t;

    typedef struct {
        logic [4:0] op;
        int         ra, rb, rc;
        int         w;          // T1 cycles before mem_ready (NO_READY = never)
        int         lat;        // cycles from start acceptance to done, 0 = none
        logic       err;        // error expected afterwards
    } vec_t;

    cyc_t sched[$];

    function automatic logic [57:0] pack(input cyc_t c);
        return {c.bus, c.rin, c.strb, c.inc, c.mrd, c.alu, c.bsy, c.dn, c.err};
    endfunction

    function automatic cyc_t blank(input logic bsy, input logic err);
        cyc_t c;
        c.bus = '0; c.rin = '0; c.strb = '0; c.inc = 1'b0; c.mrd = 1'b0;
        c.alu = '0; c.bsy = bsy; c.dn = 1'b0; c.err = err; c.mr = 1'b0;
        return c;
    endfunction

    // Reference model: expected control words for one instruction.
    function automatic void build(input logic [4:0] op, input int ra, input int rb,
                                  input int rc, input int w);
        cyc_t c;
        int   n_t1;
        sched.delete();
        // fetch: PC -> MAR, Z <= PC + 1
        c = blank(1'b1, 1'b0);
        c.bus = 24'd1 << 20; c.strb[B_MAR] = 1'b1; c.strb[B_Z] = 1'b1; c.inc = 1'b1;
        sched.push_back(c);
        // memory read: held until ready, at most 15 cycles
        n_t1 = (w < NO_READY) ? w + 1 : 15;
        for (int j = 0; j < n_t1; j++) begin
            c = blank(1'b1, 1'b0);
            c.bus = 24'd1 << 19; c.strb[B_PC] = 1'b1; c.strb[B_MDR] = 1'b1; c.mrd = 1'b1;
            c.mr = (j == w);
            sched.push_back(c);
        end
        if (w >= NO_READY) return;
        c = blank(1'b1, 1'b0);
        c.bus = 24'd1 << 21; c.strb[B_IR] = 1'b1;
        sched.push_back(c);
        c = blank(1'b1, 1'b0);
        c.bus = 24'd1 << rb; c.strb[B_Y] = 1'b1;
        sched.push_back(c);
        c = blank(1'b1, 1'b0);
        c.bus = 24'd1 << rc; c.strb[B_Z] = 1'b1; c.alu = op;
        sched.push_back(c);
        c = blank(1'b1, 1'b0);
        c.bus = 24'd1 << 19;
        if (op == MUL_OP || op == DIV_OP) begin
            c.strb[B_LO] = 1'b1;
            sched.push_back(c);
            c = blank(1'b1, 1'b0);
            c.bus = 24'd1 << 18; c.strb[B_HI] = 1'b1; c.dn = 1'b1;
            sched.push_back(c);
        end else begin
            c.rin = 16'd1 << ra; c.dn = 1'b1;
            sched.push_back(c);
        end
    endfunction

    task automatic chk(input string name, input logic [57:0] act, input logic [57:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction from IDLE and compares every cycle with the model.
    // pulse_at: schedule index at which start is pulsed again (-1 = never).
    task automatic run_instr(input logic [4:0] op, input int ra, input int rb,
                             input int rc, input int w, input int pulse_at,
                             output int lat);
        build(op, ra, rb, rc, w);
        ir_op = op; ir_ra = 4'(ra); ir_rb = 4'(rb); ir_rc = 4'(rc);
        mem_ready = 1'b0;
        start = 1'b1;
        step();
        lat = 0;
        for (int i = 0; i < sched.size(); i++) begin
            chk("cycle_word", obs, pack(sched[i]));
            chk_int("onehot_inv", int'($countones(bus_src) <= 1 && $countones(reg_in) <= 1), 1);
            if (done) lat = i + 1;
            mem_ready = sched[i].mr;
            start = (i == pulse_at);
            step();
        end
        start = 1'b0;
        mem_ready = 1'b0;
        chk("idle_after", obs, pack(blank(1'b0, (w >= NO_READY))));
        $display("instr op=%0d ra=%0d rb=%0d rc=%0d wait=%0d latency=%0d error=%0b",
                 op, ra, rb, rc, w, lat, error);
    endtask

    vec_t vecs[8];
    int   lat;

    initial begin
        // Directed table: latencies stated from the timing rules, not the model.
        vecs[0] = '{op: 5'd3,   ra: 4,  rb: 2,  rc: 7,  w: 0,        lat: 6,  err: 1'b0};
        vecs[1] = '{op: MUL_OP, ra: 1,  rb: 3,  rc: 5,  w: 0,        lat: 7,  err: 1'b0};
        vecs[2] = '{op: 5'd3,   ra: 4,  rb: 2,  rc: 7,  w: 3,        lat: 9,  err: 1'b0};
        vecs[3] = '{op: DIV_OP, ra: 15, rb: 0,  rc: 14, w: 2,        lat: 9,  err: 1'b0};
        vecs[4] = '{op: 5'd0,   ra: 9,  rb: 9,  rc: 9,  w: 1,        lat: 7,  err: 1'b0};
        vecs[5] = '{op: 5'd3,   ra: 2,  rb: 4,  rc: 6,  w: NO_READY, lat: 0,  err: 1'b1};
        vecs[6] = '{op: 5'd31,  ra: 0,  rb: 15, rc: 0,  w: 14,       lat: 20, err: 1'b0};
        vecs[7] = '{op: MUL_OP, ra: 3,  rb: 1,  rc: 2,  w: 14,       lat: 21, err: 1'b0};

        // ---------------- reset held with start high ----------------
        reset = 1'b1; start = 1'b1; mem_ready = 1'b0;
        ir_op = '0; ir_ra = '0; ir_rb = '0; ir_rc = '0;
        step();
        chk("reset_cycle1", obs, 58'd0);
        step();
        chk("reset_cycle2", obs, 58'd0);
        reset = 1'b0; start = 1'b0;
        step();
        chk("idle_no_start", obs, 58'd0);

        // ---------------- directed table ----------------
        for (int v = 0; v < 8; v++) begin
            run_instr(vecs[v].op, vecs[v].ra, vecs[v].rb, vecs[v].rc, vecs[v].w, -1, lat);
            chk_int("latency", lat, vecs[v].lat);
            chk_int("error_flag", int'(error), int'(vecs[v].err));
            if (vecs[v].err) begin
                // error is sticky while idle
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("error_sticky", obs, pack(blank(1'b0, 1'b1)));
                end
            end
        end

        // ---------------- reset during T3 ----------------
        ir_op = 5'd3; ir_ra = 4'd4; ir_rb = 4'd2; ir_rc = 4'd7;
        start = 1'b1; mem_ready = 1'b1;
        step();                 // T0
        start = 1'b0;
        step();                 // T1 (ready)
        step();                 // T2
        step();                 // T3
        chk("pre_reset_t3", {34'd0, bus_src}, {34'd0, 24'h000004});
        reset = 1'b1;
        step();
        chk("reset_mid_run", obs, 58'd0);
        reset = 1'b0; mem_ready = 1'b0;
        step();
        chk("stay_idle_after_reset", obs, 58'd0);

        // ---------------- start pulsed during T4 is dropped ----------------
        run_instr(5'd3, 4, 2, 7, 0, 4, lat);   // index 4 of the schedule is T4
        chk_int("pulse_latency", lat, 6);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_queued_start", obs, 58'd0);
        end

        // ---------------- start held high: one idle bubble ----------------
        ir_op = 5'd3; ir_ra = 4'd4; ir_rb = 4'd2; ir_rc = 4'd7;
        start = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();    // T0..T5
        chk_int("held_done", int'(done), 1);
        step();
        chk_int("held_bubble_busy", int'(busy), 0);
        step();
        chk("held_restart_t0", {34'd0, bus_src}, {34'd0, 24'h100000});
        start = 1'b0; mem_ready = 1'b0;
        begin
            int budget;
            budget = 0;
            mem_ready = 1'b1;
            while (busy && budget < 40) begin
                step();
                budget++;
            end
            mem_ready = 1'b0;
            chk_int("held_drain_bounded", int'(busy), 0);
        end

        // ---------------- random instructions ----------------
        for (int n = 0; n < 24; n++) begin
            logic [4:0] op;
            int         w, exp_lat, sel;
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? MUL_OP : (sel == 1) ? DIV_OP : 5'($urandom_range(0, 31));
            w   = ($urandom_range(0, 7) == 0) ? NO_READY : $urandom_range(0, 6);
            exp_lat = (w >= NO_READY) ? 0 :
                      6 + w + ((op == MUL_OP || op == DIV_OP) ? 1 : 0);
            run_instr(op, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), w, -1, lat);
            chk_int("rand_latency", lat, exp_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends with a summary.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
